// File: rtl/scc_rf_pkg.sv
// Shared encodings for the scoreboarded register file: write merge modes
// and write-source select.
package scc_rf_pkg;

   localparam logic [1:0] WR_FULL = 2'd0;
   localparam logic [1:0] WR_HIGH = 2'd1;
   localparam logic [1:0] WR_SET  = 2'd2;
   localparam logic [1:0] WR_CLR  = 2'd3;

   localparam logic SEL_ID  = 1'b0;
   localparam logic SEL_EXE = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: ID claims a destination, the write-back clears it.
// A claim in the same cycle as a clear wins so a destination can be reused.
module rf_scoreboard #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                claim_en,
   input  logic [ADDR_W-1:0]   claim_addr,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   output logic [NUM_REGS-1:0] pending,
   output logic                claim_err
);

   logic [NUM_REGS-1:0] pending_nxt;
   logic                claim_err_nxt;

   // Clear applied first so a coincident claim overrides it
   always_comb begin
      pending_nxt = pending;
      if (wr_en)
         pending_nxt[wr_addr] = 1'b0;
      if (claim_en)
         pending_nxt[claim_addr] = 1'b1;
      claim_err_nxt = claim_en && pending[claim_addr] &&
                      !(wr_en && (wr_addr == claim_addr));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         claim_err <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         claim_err <= claim_err_nxt;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with merge-mode writes, optional write-to-read
// bypass and a pending-write scoreboard for RAW hazard stalls.
module reg_file_sb
   import scc_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [1:0]                 wr_mode,
   input  logic                       wr_sel,
   input  logic [DATA_W-1:0]          wr_data_id,
   input  logic [DATA_W-1:0]          wr_data_exe,
   input  logic                       claim_en,
   input  logic [ADDR_W-1:0]          claim_addr,
   output logic [NUM_REGS-1:0]        pending,
   output logic                       claim_err
);

   localparam int unsigned HALF_W = DATA_W / 2;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] src_c;
   logic [DATA_W-1:0] cur_c;
   logic [DATA_W-1:0] merge_c;

   // Merged write value; HIGH keeps the low half of the destination (MOVT)
   always_comb begin
      src_c = (wr_sel == SEL_ID) ? wr_data_id : wr_data_exe;
      cur_c = regs[wr_addr];
      case (wr_mode)
         WR_FULL: merge_c = src_c;
         WR_HIGH: merge_c = {src_c[HALF_W-1:0], cur_c[HALF_W-1:0]};
         WR_SET:  merge_c = '1;
         default: merge_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= merge_c;
      end
   end

   // A bypassed write also satisfies the hazard on that port this cycle
   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      assign addr = rd_addr[k*ADDR_W +: ADDR_W];
      assign hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);
      assign rd_data[k*DATA_W +: DATA_W] = hit ? merge_c : regs[addr];
      assign rd_busy[k] = pending[addr] && !hit;
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .pending    (pending),
      .claim_err  (claim_err)
   );

endmodule
